data_bus_interconnect: RTL and testbench
========================================

Name: data_bus_interconnect

Overview:
Parametrised CPU data-bus interconnect between the RS5 core data port and N memory-mapped slaves (BRAM, peripherals, future accelerators). It replaces the fixed two-way BRAM/peripheral address split with a table of base/mask regions. Each region is either fixed-latency (1-cycle read, no stall) or handshake (variable latency via ready, with stall to the core). Unmapped accesses and handshake timeouts are reported as bus errors with a captured fault address.

Parameters:
N_SLAVES, 4, number of slave ports (1..16)
BASE_ADDR, {32'h3000_0000, 32'h2000_0000, 32'h0001_0000, 32'h0000_0000}, packed N_SLAVES*32 region bases; slave k at bits [32k+:32]
ADDR_MASK, {4{32'hFFFF_0000}}, packed N_SLAVES*32 region masks; hit when (addr & mask) == base
FIXED_LATENCY, 4'b0001, bit k = 1: slave k is fixed 1-cycle, ignores ready_i[k]
TIMEOUT_CYCLES, 255, max WAIT cycles before a handshake access aborts (>=1)
ERR_DATA, 32'h0000_0000, read data returned on error

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable_i  input  1  core request valid
write_enable_i  input  4  byte write strobes; 0 = read
address_i  input  32  core data address
data_i  input  32  core write data
data_o  output  32  read data to core
stall_o  output  1  hold core pipeline
slv_enable_o  output  N_SLAVES  one-hot slave select
slv_write_enable_o  output  4  pass-through of write_enable_i
slv_address_o  output  32  pass-through of address_i
slv_data_o  output  32  pass-through of data_i
slv_data_i  input  N_SLAVES*32  slave read data, slave k at [32k+:32]
slv_ready_i  input  N_SLAVES  handshake completion per slave
error_o  output  1  one-cycle bus-error pulse
err_addr_o  output  32  address of last faulting access

Behaviour:
- Decode: hit[k] = (address_i & MASK_k) == BASE_k; lowest index wins on overlap; no hit = unmapped.
- FSM states IDLE, WAIT. Reset: IDLE, sel_q=0, rsrc_q=NONE, rdata_q=0, cnt=0, error_o=0, err_addr_o=0; slv_enable_o=0, stall_o=0, data_o=ERR_DATA.
- IDLE, enable_i, fixed slave k: slv_enable_o[k]=1 this cycle (T), stall_o=0; rsrc_q<=SLAVE(k); data_o at T+1 = slv_data_i[k] (combinational from registered select). Back-to-back fixed accesses every cycle.
- IDLE, enable_i, handshake slave k: slv_enable_o[k]=1; stall_o = !slv_ready_i[k]. If ready at T: rdata_q<=slv_data_i[k], rsrc_q<=CAPTURED, stay IDLE. Else sel_q<=k, cnt<=1, -> WAIT.
- WAIT: slv_enable_o[sel_q]=1 (core holds address/data while stalled); stall_o = !slv_ready_i[sel_q].
  - ready: rdata_q<=slv_data_i[sel_q], rsrc_q<=CAPTURED, -> IDLE; data_o at next cycle = rdata_q.
  - no ready and cnt==TIMEOUT_CYCLES: stall_o=0, slv_enable_o=0 that cycle; error_o=1 next cycle; err_addr_o<=address_i; rdata_q<=ERR_DATA; -> IDLE.
  - else cnt<=cnt+1 (width $clog2(TIMEOUT_CYCLES+1), never wraps).
- IDLE, enable_i, unmapped: no slave enabled, stall_o=0; next cycle error_o=1, data_o=ERR_DATA; err_addr_o<=address_i.
- enable_i low in IDLE: no enable, no stall; rsrc_q<=NONE (data_o=ERR_DATA).
- Writes follow the same paths; read data is ignored by the core; errors reported identically.
- error_o: single-cycle pulse; consecutive faults give consecutive pulses.
- Ready on a slave not selected: ignored.
- Reset asserted mid-WAIT: immediately IDLE, all outputs at reset values; slave sees enable drop asynchronously.

Decomposition:
- my_pkg: bus_state_t enum {IDLE, WAIT}; rsrc_t enum {NONE, SLAVE, CAPTURED}; BUS_ERR_DATA default constant.
- Sub-module bus_addr_decoder: combinational, params N_SLAVES/BASE_ADDR/ADDR_MASK; outputs one-hot hit plus hit_any; unit-testable alone.

Test Plan:
- Read 0x0000_0010 (slave0 fixed) for 3 consecutive cycles, data 0xA,0xB,0xC -> stall_o=0 throughout, data_o=0xA,0xB,0xC at T+1..T+3.
- Read 0x0001_0004 (slave1), ready after 3 cycles with 0x1234_5678 -> stall_o high 3 cycles, low on ready cycle, data_o=0x1234_5678 next cycle, no error.
- Write 0x2000_0000 with slave2 never ready, TIMEOUT_CYCLES=255 -> stall released after 256 request cycles, error_o pulse 1 cycle, err_addr_o=0x2000_0000.
- Read 0x4000_0000 (unmapped) -> no slv_enable_o bit, stall_o=0, next cycle error_o=1, data_o=0, err_addr_o=0x4000_0000.
- Overlap: BASE1=BASE0 with equal masks -> only slv_enable_o[0] asserted.
- Assert reset during WAIT on slave1 -> stall_o=0, slv_enable_o=0 immediately; after release, fixed read to slave0 completes normally.

Source files
------------

// File: rtl/data_bus_interconnect_pkg.sv
// Shared types and constants for the core data-bus interconnect.
package data_bus_interconnect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bus_state_t;

    // Where data_o comes from in the cycle after a request.
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        SLAVE    = 2'd1,
        CAPTURED = 2'd2
    } rsrc_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/data_bus_interconnect_decoder.sv
// Base/mask region decoder: one-hot hit on the lowest-index matching region.
module bus_addr_decoder #(
    parameter int                      N_SLAVES  = 4,
    parameter logic [N_SLAVES*32-1:0] BASE_ADDR = {32'h3000_0000, 32'h2000_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] ADDR_MASK = {N_SLAVES{32'hFFFF_0000}}
) (
    input  logic [31:0]         address_i,
    output logic [N_SLAVES-1:0] hit_o,
    output logic                hit_any_o
);

    logic [N_SLAVES-1:0] raw_hit;

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_region
        assign raw_hit[g] = (address_i & ADDR_MASK[32*g +: 32]) == BASE_ADDR[32*g +: 32];
    end

    // Isolating the lowest set bit gives lowest-index priority on overlaps.
    assign hit_o     = raw_hit & (~raw_hit + N_SLAVES'(1));
    assign hit_any_o = |raw_hit;

endmodule

// File: rtl/data_bus_interconnect.sv
// Core data-port interconnect: fixed-latency and handshake slaves, bus errors on
// unmapped addresses and handshake timeouts.
module data_bus_interconnect
    import data_bus_interconnect_pkg::*;
#(
    parameter int                      N_SLAVES       = 4,
    parameter logic [N_SLAVES*32-1:0] BASE_ADDR      = {32'h3000_0000, 32'h2000_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] ADDR_MASK      = {N_SLAVES{32'hFFFF_0000}},
    parameter logic [N_SLAVES-1:0]    FIXED_LATENCY  = N_SLAVES'(1),
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERR_DATA       = BUS_ERR_DATA
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic [3:0]             write_enable_i,
    input  logic [31:0]            address_i,
    input  logic [31:0]            data_i,
    output logic [31:0]            data_o,
    output logic                   stall_o,
    output logic [N_SLAVES-1:0]    slv_enable_o,
    output logic [3:0]             slv_write_enable_o,
    output logic [31:0]            slv_address_o,
    output logic [31:0]            slv_data_o,
    input  logic [N_SLAVES*32-1:0] slv_data_i,
    input  logic [N_SLAVES-1:0]    slv_ready_i,
    output logic                   error_o,
    output logic [31:0]            err_addr_o
);

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    bus_state_t          state_q;
    rsrc_t               rsrc_q;
    logic [IW-1:0]       sel_q, rsel_q, hit_idx;
    logic [CW-1:0]       cnt_q;
    logic [31:0]         rdata_q;
    logic [N_SLAVES-1:0] hit;
    logic                hit_any, hit_fixed, timeout;

    bus_addr_decoder #(
        .N_SLAVES  (N_SLAVES),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_dec (
        .address_i (address_i),
        .hit_o     (hit),
        .hit_any_o (hit_any)
    );

    always_comb begin
        hit_idx = '0;
        for (int k = 0; k < N_SLAVES; k++)
            if (hit[k]) hit_idx = IW'(k);
    end

    assign hit_fixed          = FIXED_LATENCY[hit_idx];
    assign timeout            = (state_q == WAIT) && !slv_ready_i[sel_q] && (cnt_q == CNT_MAX);
    assign slv_write_enable_o = write_enable_i;
    assign slv_address_o      = address_i;
    assign slv_data_o         = data_i;

    // Request outputs are gated by reset so the slave sees enable drop at once.
    always_comb begin
        slv_enable_o = '0;
        stall_o      = 1'b0;
        if (reset) begin
            if (state_q == IDLE) begin
                if (enable_i && hit_any) begin
                    slv_enable_o = hit;
                    stall_o      = !hit_fixed && !slv_ready_i[hit_idx];
                end
            end else if (!timeout) begin
                slv_enable_o[sel_q] = 1'b1;
                stall_o             = !slv_ready_i[sel_q];
            end
        end
    end

    always_comb begin
        data_o = ERR_DATA;
        case (rsrc_q)
            SLAVE:    data_o = slv_data_i[32*rsel_q +: 32];
            CAPTURED: data_o = rdata_q;
            default:  data_o = ERR_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rsrc_q     <= NONE;
            sel_q      <= '0;
            rsel_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            error_o    <= 1'b0;
            err_addr_o <= '0;
        end else begin
            error_o <= 1'b0;
            if (state_q == IDLE) begin
                rsrc_q <= NONE;
                if (enable_i && !hit_any) begin
                    error_o    <= 1'b1;
                    err_addr_o <= address_i;
                end else if (enable_i && hit_fixed) begin
                    rsrc_q <= SLAVE;
                    rsel_q <= hit_idx;
                end else if (enable_i && slv_ready_i[hit_idx]) begin
                    rdata_q <= slv_data_i[32*hit_idx +: 32];
                    rsrc_q  <= CAPTURED;
                end else if (enable_i) begin
                    sel_q   <= hit_idx;
                    cnt_q   <= CW'(1);
                    state_q <= WAIT;
                end
            end else begin
                if (slv_ready_i[sel_q]) begin
                    rdata_q <= slv_data_i[32*sel_q +: 32];
                    rsrc_q  <= CAPTURED;
                    state_q <= IDLE;
                end else if (timeout) begin
                    error_o    <= 1'b1;
                    err_addr_o <= address_i;
                    rdata_q    <= ERR_DATA;
                    rsrc_q     <= CAPTURED;
                    state_q    <= IDLE;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_bus_interconnect.sv
// Directed bench for data_bus_interconnect: single-cycle vector table plus
// multi-cycle sequences for back-to-back, handshake, timeout, reset and overlap.
module tb_data_bus_interconnect;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [3:0]   we;
    logic [31:0]  addr, wdata;
    logic [31:0]  data_o;
    logic         stall;
    logic [3:0]   slv_en;
    logic [3:0]   slv_we;
    logic [31:0]  slv_addr, slv_wdata;
    logic [127:0] slv_rdata;
    logic [3:0]   slv_rdy;
    logic         error;
    logic [31:0]  err_addr;

    // Second instance with two identical regions for the overlap check.
    logic         ov_en;
    logic [31:0]  ov_addr;
    logic [31:0]  ov_data_o, ov_slv_addr, ov_slv_wdata, ov_err_addr;
    logic         ov_stall, ov_error;
    logic [1:0]   ov_slv_en;
    logic [3:0]   ov_slv_we;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_bus_interconnect dut (
        .clk                (clk),
        .reset              (rst_n),
        .enable_i           (enable),
        .write_enable_i     (we),
        .address_i          (addr),
        .data_i             (wdata),
        .data_o             (data_o),
        .stall_o            (stall),
        .slv_enable_o       (slv_en),
        .slv_write_enable_o (slv_we),
        .slv_address_o      (slv_addr),
        .slv_data_o         (slv_wdata),
        .slv_data_i         (slv_rdata),
        .slv_ready_i        (slv_rdy),
        .error_o            (error),
        .err_addr_o         (err_addr)
    );

    data_bus_interconnect #(
        .N_SLAVES      (2),
        .BASE_ADDR     (64'h0),
        .ADDR_MASK     ({2{32'hFFFF_0000}}),
        .FIXED_LATENCY (2'b11)
    ) dut_ov (
        .clk                (clk),
        .reset              (rst_n),
        .enable_i           (ov_en),
        .write_enable_i     (4'h0),
        .address_i          (ov_addr),
        .data_i             (32'h0),
        .data_o             (ov_data_o),
        .stall_o            (ov_stall),
        .slv_enable_o       (ov_slv_en),
        .slv_write_enable_o (ov_slv_we),
        .slv_address_o      (ov_slv_addr),
        .slv_data_o         (ov_slv_wdata),
        .slv_data_i         (64'h1111_1111_0000_0000),
        .slv_ready_i        (2'b00),
        .error_o            (ov_error),
        .err_addr_o         (ov_err_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [3:0]  rdy;
        logic [3:0]  x_sen;
        logic        x_stall;
        logic        x_err;
        logic [31:0] x_data;
    } vec_t;

    vec_t vt[9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_eaddr;
        int          ncyc;
        logic        done;

        //            en    we     addr            rdy      sen      stall err   data_next
        vt[0] = '{1'b0, 4'h0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0};
        vt[1] = '{1'b1, 4'h0, 32'h0000_0010, 4'b0000, 4'b0001, 1'b0, 1'b0, 32'hD0D0_0000};
        vt[2] = '{1'b1, 4'h0, 32'h0001_0004, 4'b0010, 4'b0010, 1'b0, 1'b0, 32'hD1D1_0001};
        vt[3] = '{1'b1, 4'h0, 32'h3000_0008, 4'b1111, 4'b1000, 1'b0, 1'b0, 32'hD3D3_0003};
        vt[4] = '{1'b1, 4'h0, 32'h4000_0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 32'h0};
        vt[5] = '{1'b1, 4'hF, 32'h5555_0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0};
        vt[6] = '{1'b1, 4'h3, 32'h2000_0010, 4'b0100, 4'b0100, 1'b0, 1'b0, 32'hD2D2_0002};
        vt[7] = '{1'b1, 4'h0, 32'h0000_FFFC, 4'b0000, 4'b0001, 1'b0, 1'b0, 32'hD0D0_0000};
        vt[8] = '{1'b0, 4'h0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0};

        rst_n     = 1'b0;
        enable    = 1'b0;
        we        = 4'h0;
        addr      = 32'h0;
        wdata     = 32'h0;
        slv_rdy   = 4'h0;
        slv_rdata = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        ov_en     = 1'b0;
        ov_addr   = 32'h0;
        exp_eaddr = 32'h0;

        #12;
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_error", {31'h0, error}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_slv_en", {28'h0, slv_en}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle transactions: outputs in cycle T, results in cycle T+1.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("vec%0d_error", i-1), {31'h0, error}, {31'h0, vt[i-1].x_err});
                chk($sformatf("vec%0d_data_o", i-1), data_o, vt[i-1].x_data);
                chk($sformatf("vec%0d_err_addr", i-1), err_addr, exp_eaddr);
            end
            enable  = vt[i].en;
            we      = vt[i].we;
            addr    = vt[i].addr;
            wdata   = ~vt[i].addr;
            slv_rdy = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d_slv_en", i), {28'h0, slv_en}, {28'h0, vt[i].x_sen});
            chk($sformatf("vec%0d_stall", i), {31'h0, stall}, {31'h0, vt[i].x_stall});
            chk($sformatf("vec%0d_slv_addr", i), slv_addr, vt[i].addr);
            chk($sformatf("vec%0d_slv_we", i), {28'h0, slv_we}, {28'h0, vt[i].we});
            chk($sformatf("vec%0d_slv_wdata", i), slv_wdata, ~vt[i].addr);
            if (vt[i].x_err) exp_eaddr = vt[i].addr;
        end
        @(negedge clk);
        #1;
        chk("vec8_error", {31'h0, error}, 32'h0);
        chk("vec8_data_o", data_o, 32'h0);
        chk("vec8_err_addr", err_addr, exp_eaddr);

        // Back-to-back fixed reads: BRAM returns data the cycle after the request.
        @(negedge clk);
        enable = 1'b1; we = 4'h0; addr = 32'h0000_0010; slv_rdy = 4'h0;
        #1 chk("b2b_stall0", {31'h0, stall}, 32'h0);
        @(negedge clk);
        slv_rdata[31:0] = 32'hA;
        #1 chk("b2b_data_a", data_o, 32'hA);
        chk("b2b_stall1", {31'h0, stall}, 32'h0);
        @(negedge clk);
        slv_rdata[31:0] = 32'hB;
        #1 chk("b2b_data_b", data_o, 32'hB);
        chk("b2b_stall2", {31'h0, stall}, 32'h0);
        @(negedge clk);
        enable = 1'b0;
        slv_rdata[31:0] = 32'hC;
        #1 chk("b2b_data_c", data_o, 32'hC);
        @(negedge clk);
        #1 chk("b2b_idle_data", data_o, 32'h0);

        // Handshake read on slave1, ready after three stalled cycles; other slaves' ready ignored.
        @(negedge clk);
        enable = 1'b1; addr = 32'h0001_0004; slv_rdy = 4'b1101;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            chk($sformatf("hs_stall%0d", j), {31'h0, stall}, 32'h1);
            chk($sformatf("hs_slv_en%0d", j), {28'h0, slv_en}, 32'h2);
        end
        @(negedge clk);
        slv_rdy = 4'b0010;
        slv_rdata[63:32] = 32'h1234_5678;
        #1 chk("hs_ready_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        enable = 1'b0; slv_rdy = 4'h0;
        slv_rdata[63:32] = 32'hDEAD_BEEF;
        #1 chk("hs_data_o", data_o, 32'h1234_5678);
        chk("hs_no_error", {31'h0, error}, 32'h0);

        // Handshake write to slave2 that never answers.
        @(negedge clk);
        enable = 1'b1; we = 4'hF; addr = 32'h2000_0000; slv_rdy = 4'h0;
        ncyc = 0;
        done = 1'b0;
        for (int j = 0; j < 300 && !done; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            ncyc++;
            if (!stall) done = 1'b1;
        end
        chk("to_request_cycles", ncyc, 256);
        chk("to_slv_en_dropped", {28'h0, slv_en}, 32'h0);
        chk("to_no_early_error", {31'h0, error}, 32'h0);
        @(negedge clk);
        enable = 1'b0; we = 4'h0;
        #1 chk("to_error", {31'h0, error}, 32'h1);
        chk("to_err_addr", err_addr, 32'h2000_0000);
        chk("to_data_o", data_o, 32'h0);
        @(negedge clk);
        #1 chk("to_error_pulse_end", {31'h0, error}, 32'h0);

        // Reset asserted mid-WAIT on slave1, then a normal fixed read.
        @(negedge clk);
        enable = 1'b1; addr = 32'h0001_0004; slv_rdy = 4'h0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("rw_stall_before", {31'h0, stall}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rw_stall", {31'h0, stall}, 32'h0);
        chk("rw_slv_en", {28'h0, slv_en}, 32'h0);
        chk("rw_data_o", data_o, 32'h0);
        chk("rw_err_addr", err_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        addr = 32'h0000_0010;
        slv_rdata[31:0] = 32'h5A5A_5A5A;
        #1 chk("rw_fixed_slv_en", {28'h0, slv_en}, 32'h1);
        chk("rw_fixed_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        enable = 1'b0;
        #1 chk("rw_fixed_data", data_o, 32'h5A5A_5A5A);

        // Overlapping regions: only the lowest index is selected.
        @(negedge clk);
        ov_en = 1'b1; ov_addr = 32'h0000_0100;
        #1 chk("ov_slv_en", {30'h0, ov_slv_en}, 32'h1);
        @(negedge clk);
        ov_en = 1'b0;
        #1 chk("ov_data_o", ov_data_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
